// File: rtl/result_accumulator.sv
// result_accumulator: collects batches of unsigned result samples over a
// valid/ready handshake and presents sum, max, min and count of each batch
// on a second valid/ready handshake. A flush closes a partial batch early.
module result_accumulator #(
  parameter int WIDTH = 5,
  parameter int BATCH = 4,
  localparam int SUM_W = WIDTH + $clog2(BATCH),
  localparam int CNT_W = $clog2(BATCH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  input  logic             io_flush,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [SUM_W-1:0] io_out_sum,
  output logic [WIDTH-1:0] io_out_max,
  output logic [WIDTH-1:0] io_out_min,
  output logic [CNT_W-1:0] io_out_count
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] BATCH_CNT = CNT_W'(BATCH);

  state_t             state_r, state_n;
  logic [SUM_W-1:0]   acc_r,   acc_n;
  logic [WIDTH-1:0]   max_r,   max_n;
  logic [WIDTH-1:0]   min_r,   min_n;
  logic [CNT_W-1:0]   cnt_r,   cnt_n;

  logic               accept_s;
  logic [SUM_W-1:0]   bits_ext_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  assign accept_s   = io_in_valid && io_in_ready;
  assign bits_ext_s = {{(SUM_W-WIDTH){1'b0}}, io_in_bits};
  assign cnt_inc_s  = cnt_r + CNT_W'(1);

  // Statistics are presented straight from the state registers.
  assign io_out_valid = (state_r == DONE);
  assign io_out_sum   = acc_r;
  assign io_out_max   = max_r;
  assign io_out_min   = min_r;
  assign io_out_count = cnt_r;

  // Input ready: always open while collecting; while holding a result, only
  // when that result is being taken this cycle (so the next batch starts
  // without a bubble).
  always_comb begin
    io_in_ready = 1'b0;
    case (state_r)
      ACCUM:   io_in_ready = 1'b1;
      DONE:    io_in_ready = io_out_ready;
      default: io_in_ready = 1'b0;
    endcase
  end

  // Next-state and next-statistics decode for the collect/hold machine.
  always_comb begin
    state_n = state_r;
    acc_n   = acc_r;
    max_n   = max_r;
    min_n   = min_r;
    cnt_n   = cnt_r;
    case (state_r)
      ACCUM: begin
        if (accept_s) begin
          acc_n = acc_r + bits_ext_s;
          max_n = (io_in_bits > max_r) ? io_in_bits : max_r;
          min_n = (io_in_bits < min_r) ? io_in_bits : min_r;
          cnt_n = cnt_inc_s;
          // A flush arriving with a beat closes the batch including that beat.
          if ((cnt_inc_s == BATCH_CNT) || io_flush) begin
            state_n = DONE;
          end else begin
            state_n = ACCUM;
          end
        end else if (io_flush && (cnt_r != {CNT_W{1'b0}})) begin
          state_n = DONE;
        end else begin
          // Flush of an empty batch is meaningless and dropped.
          state_n = ACCUM;
        end
      end
      DONE: begin
        if (io_out_ready) begin
          state_n = ACCUM;
          if (accept_s) begin
            // Beat taken in the handshake cycle seeds the next batch.
            acc_n = bits_ext_s;
            max_n = io_in_bits;
            min_n = io_in_bits;
            cnt_n = CNT_W'(1);
          end else begin
            acc_n = {SUM_W{1'b0}};
            max_n = {WIDTH{1'b0}};
            min_n = {WIDTH{1'b1}};
            cnt_n = {CNT_W{1'b0}};
          end
        end else begin
          // Result held stable under backpressure; flush is not remembered.
          state_n = DONE;
        end
      end
      default: begin
        state_n = ACCUM;
        acc_n   = {SUM_W{1'b0}};
        max_n   = {WIDTH{1'b0}};
        min_n   = {WIDTH{1'b1}};
        cnt_n   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and statistics registers with synchronous reset to the empty batch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ACCUM;
      acc_r   <= {SUM_W{1'b0}};
      max_r   <= {WIDTH{1'b0}};
      min_r   <= {WIDTH{1'b1}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_n;
      acc_r   <= acc_n;
      max_r   <= max_n;
      min_r   <= min_n;
      cnt_r   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_result_accumulator.sv
// Directed plus randomized-stall bench for result_accumulator.
module tb_result_accumulator;

  logic       clock;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [4:0] io_in_bits;
  logic       io_flush;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [6:0] io_out_sum;
  logic [4:0] io_out_max;
  logic [4:0] io_out_min;
  logic [2:0] io_out_count;

  int n_vec;
  int n_bad;

  result_accumulator #(.WIDTH(5), .BATCH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_flush     (io_flush),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_sum   (io_out_sum),
    .io_out_max   (io_out_max),
    .io_out_min   (io_out_min),
    .io_out_count (io_out_count)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_vec = n_vec + 1;
    if (got != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int v, input int s,
                           input int mx, input int mn, input int c);
    check({tag, ".valid"}, int'(io_out_valid), v);
    check({tag, ".sum"},   int'(io_out_sum),   s);
    check({tag, ".max"},   int'(io_out_max),   mx);
    check({tag, ".min"},   int'(io_out_min),   mn);
    check({tag, ".count"}, int'(io_out_count), c);
  endtask

  // One beat presented for exactly one cycle; the DUT must be ready.
  task automatic send(input logic [4:0] b, input logic fl);
    @(negedge clock);
    io_in_valid = 1'b1;
    io_in_bits  = b;
    io_flush    = fl;
    #1;
    check("send.in_ready", int'(io_in_ready), 1);
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    io_flush    = 1'b0;
  endtask

  // Reference model state for the random phase
  bit         m_done;
  int         m_acc, m_max, m_min, m_cnt;
  int         m_batches;
  logic       r_v, r_r, r_f;
  logic [4:0] r_b;

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_in_bits = 5'd0;
    io_flush = 1'b0;
    io_out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_out("reset", 0, 0, 0, 31, 0);
    check("reset.in_ready", int'(io_in_ready), 1);
    reset = 1'b0;

    // Full batch 3,7,31,0
    io_out_ready = 1'b1;
    send(5'd3, 1'b0);
    send(5'd7, 1'b0);
    send(5'd31, 1'b0);
    @(negedge clock);
    check("full.pre_valid", int'(io_out_valid), 0);
    send(5'd0, 1'b0);
    @(negedge clock);
    check_out("full", 1, 41, 31, 0, 4);
    @(posedge clock);
    @(negedge clock);
    check_out("full.consumed", 0, 0, 0, 31, 0);

    // Flush partial: 5, 9, then 2 with flush
    send(5'd5, 1'b0);
    send(5'd9, 1'b0);
    send(5'd2, 1'b1);
    @(negedge clock);
    check_out("flush", 1, 16, 9, 2, 3);
    @(posedge clock);
    // Flush with empty batch is ignored
    @(negedge clock);
    io_flush = 1'b1;
    @(posedge clock);
    #1 io_flush = 1'b0;
    @(negedge clock);
    check_out("flush.empty", 0, 0, 0, 31, 0);

    // Backpressure: 1,1,1,1 held for 5 cycles, with ignored offers and flush
    io_out_ready = 1'b0;
    repeat (4) send(5'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      io_in_valid = 1'b1;
      io_in_bits  = 5'd9;
      io_flush    = 1'b1;
      #1;
      check_out("bp.hold", 1, 4, 1, 1, 4);
      check("bp.in_ready", int'(io_in_ready), 0);
    end
    @(negedge clock);
    io_in_valid  = 1'b0;
    io_flush     = 1'b0;
    io_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_out("bp.release", 0, 0, 0, 31, 0);

    // Back-to-back: DONE with 124, handshake while accepting 6
    io_out_ready = 1'b0;
    repeat (4) send(5'd31, 1'b0);
    @(negedge clock);
    check_out("b2b.full", 1, 124, 31, 31, 4);
    io_out_ready = 1'b1;
    io_in_valid  = 1'b1;
    io_in_bits   = 5'd6;
    io_flush     = 1'b1;
    #1;
    check("b2b.in_ready", int'(io_in_ready), 1);
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    io_flush = 1'b0;
    @(negedge clock);
    check_out("b2b.seed", 0, 6, 6, 6, 1);
    io_out_ready = 1'b0;
    repeat (3) send(5'd6, 1'b0);
    @(negedge clock);
    check_out("b2b.next", 1, 24, 6, 6, 4);
    io_out_ready = 1'b1;
    @(posedge clock);

    // Reset mid-batch
    send(5'd10, 1'b0);
    send(5'd20, 1'b0);
    @(negedge clock);
    check_out("rst.partial", 0, 30, 20, 10, 2);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_out("rst.cleared", 0, 0, 0, 31, 0);
    io_out_ready = 1'b0;
    repeat (4) send(5'd2, 1'b0);
    @(negedge clock);
    check_out("rst.next", 1, 8, 2, 2, 4);
    io_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_out("rst.consumed", 0, 0, 0, 31, 0);

    // Random stall against a reference model
    m_done = 1'b0;
    m_acc = 0; m_max = 0; m_min = 31; m_cnt = 0;
    m_batches = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clock);
      r_v = 1'($urandom_range(0, 1));
      r_r = 1'($urandom_range(0, 2) != 0);
      r_f = 1'($urandom_range(0, 9) == 0);
      r_b = 5'($urandom_range(0, 31));
      io_in_valid  = r_v;
      io_out_ready = r_r;
      io_flush     = r_f;
      io_in_bits   = r_b;
      #1;
      check("rnd.in_ready", int'(io_in_ready), int'(!m_done || r_r));
      check_out("rnd", int'(m_done), m_acc, m_max, m_min, m_cnt);
      @(posedge clock);
      if (!m_done) begin
        if (r_v) begin
          m_acc = m_acc + int'(r_b);
          if (int'(r_b) > m_max) m_max = int'(r_b);
          if (int'(r_b) < m_min) m_min = int'(r_b);
          m_cnt = m_cnt + 1;
          if (m_cnt == 4 || r_f) m_done = 1'b1;
        end else if (r_f && m_cnt > 0) begin
          m_done = 1'b1;
        end
      end else if (r_r) begin
        m_batches = m_batches + 1;
        m_done = 1'b0;
        if (r_v) begin
          m_acc = int'(r_b); m_max = int'(r_b); m_min = int'(r_b); m_cnt = 1;
        end else begin
          m_acc = 0; m_max = 0; m_min = 31; m_cnt = 0;
        end
      end
    end
    check("rnd.some_batches", int'(m_batches > 50), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
